// File: rtl/csu_switch_sequencer.sv
// csu_switch_sequencer: power sequencing and code-to-switch decode for the
// current-source unit array. The path is two stages: p0 captures the
// accepted code, and p1 decodes it into the registered switch enables.
module csu_switch_sequencer #(
    parameter int SETTLE_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        dem_en,
    input  logic [4:0]  spare_sel,
    input  logic        lsb_red_en,
    input  logic [1:0]  atb_sel,
    input  logic [9:0]  code,
    input  logic        code_valid,
    output logic        code_ready,
    output logic        pdb,
    output logic [1:0]  atb_ena,
    output logic [16:0] therm_sw,
    output logic [5:0]  bin_sw,
    output logic        bin_red_sw,
    output logic [1:0]  pwr_state
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_RAMPDN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_settle_cnt;
    logic        w_pdb;
    logic        w_code_ready;
    logic        w_accept;
    logic        w_enter_settle;

    logic        r_dem_en;
    logic [4:0]  r_spare_sel;
    logic        r_lsb_red_en;

    logic [9:0]  r_code_p0;
    logic        r_vld_p0;
    logic [3:0]  r_ptr;

    logic [16:0] r_therm_p1;
    logic [5:0]  r_bin_p1;
    logic        r_red_p1;
    logic [1:0]  r_atb_p1;

    logic [3:0]  w_m;
    logic [3:0]  w_ptr_eff;

    // Places m logical units starting at ptr (mod 16), then moves the
    // logical unit chosen for replacement onto the spare unit 16.
    function automatic logic [16:0] therm_decode(input logic [3:0] m,
                                                 input logic [3:0] ptr,
                                                 input logic [4:0] spare);
        logic [16:0] ones;
        logic [15:0] base;
        logic [31:0] dbl;
        logic [15:0] logical;
        logic [16:0] phys;
        ones    = (17'd1 << m) - 17'd1;
        base    = ones[15:0];
        dbl     = {base, base} << ptr;
        logical = dbl[31:16];
        if (!spare[4]) begin
            phys = {logical[spare[3:0]], logical & ~(16'd1 << spare[3:0])};
        end else begin
            phys = {1'b0, logical};
        end
        return phys;
    endfunction

    assign w_accept       = code_valid & w_code_ready;
    assign w_enter_settle = (r_state == ST_OFF) & en;
    assign w_m            = r_code_p0[9:6];
    assign w_ptr_eff      = r_dem_en ? r_ptr : 4'd0;

    // Power state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_OFF;
        else     r_state <= w_state_nxt;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_pdb        = 1'b0;
        w_code_ready = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (en) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_pdb = 1'b1;
                if (!en) w_state_nxt = ST_OFF;
                else if (r_settle_cnt == 10'(SETTLE_CYCLES - 1)) w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                w_pdb        = 1'b1;
                w_code_ready = 1'b1;
                if (!en) w_state_nxt = ST_RAMPDN;
            end
            ST_RAMPDN: begin
                w_pdb       = 1'b1;
                w_state_nxt = ST_OFF;
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    // Settle counter runs only while staying in SETTLE, otherwise cleared.
    always_ff @(posedge clk) begin
        if (rst) r_settle_cnt <= '0;
        else if (r_state == ST_SETTLE && w_state_nxt == ST_SETTLE) r_settle_cnt <= r_settle_cnt + 10'd1;
        else r_settle_cnt <= '0;
    end

    // Configuration is frozen on the OFF->SETTLE edge for the whole power cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dem_en     <= 1'b0;
            r_spare_sel  <= 5'd0;
            r_lsb_red_en <= 1'b0;
        end else if (w_enter_settle) begin
            r_dem_en     <= dem_en;
            r_spare_sel  <= spare_sel;
            r_lsb_red_en <= lsb_red_en;
        end
    end

    // ---- p0: capture accepted code; flushed whenever leaving ACTIVE ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code_p0 <= '0;
            r_vld_p0  <= 1'b0;
        end else begin
            r_vld_p0 <= w_accept & (w_state_nxt == ST_ACTIVE);
            if (w_accept) r_code_p0 <= code;
        end
    end

    // ---- p1: decode into switch enables; forced open outside ACTIVE ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_therm_p1 <= '0;
            r_bin_p1   <= '0;
            r_red_p1   <= 1'b0;
            r_atb_p1   <= 2'b00;
            r_ptr      <= 4'd0;
        end else if (w_state_nxt != ST_ACTIVE) begin
            r_therm_p1 <= '0;
            r_bin_p1   <= '0;
            r_red_p1   <= 1'b0;
            r_atb_p1   <= 2'b00;
            if (w_enter_settle) r_ptr <= 4'd0;
        end else begin
            r_atb_p1 <= atb_sel;
            if (r_vld_p0) begin
                r_therm_p1 <= therm_decode(w_m, w_ptr_eff, r_spare_sel);
                r_bin_p1   <= {r_code_p0[5:1], r_code_p0[0] & ~r_lsb_red_en};
                r_red_p1   <= r_code_p0[0] & r_lsb_red_en;
                if (r_dem_en) r_ptr <= r_ptr + w_m;
            end
        end
    end

    assign code_ready = w_code_ready;
    assign pdb        = w_pdb;
    assign pwr_state  = r_state;
    assign atb_ena    = r_atb_p1;
    assign therm_sw   = r_therm_p1;
    assign bin_sw     = r_bin_p1;
    assign bin_red_sw = r_red_p1;

endmodule

// File: tb/tb_csu_switch_sequencer.sv
// Directed bench for csu_switch_sequencer with a scoreboard of expected
// switch states keyed by the cycle they should appear.
module tb_csu_switch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        dem_en;
    logic [4:0]  spare_sel;
    logic        lsb_red_en;
    logic [1:0]  atb_sel;
    logic [9:0]  code;
    logic        code_valid;
    logic        code_ready;
    logic        pdb;
    logic [1:0]  atb_ena;
    logic [16:0] therm_sw;
    logic [5:0]  bin_sw;
    logic        bin_red_sw;
    logic [1:0]  pwr_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [16:0] th;
        logic [5:0]  b;
        logic        r;
    } exp_t;

    exp_t sb[$];

    csu_switch_sequencer #(.SETTLE_CYCLES(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dem_en     (dem_en),
        .spare_sel  (spare_sel),
        .lsb_red_en (lsb_red_en),
        .atb_sel    (atb_sel),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .pdb        (pdb),
        .atb_ena    (atb_ena),
        .therm_sw   (therm_sw),
        .bin_sw     (bin_sw),
        .bin_red_sw (bin_red_sw),
        .pwr_state  (pwr_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due == cyc) begin
                chk("sb_therm", 32'(therm_sw), 32'(e.th));
                chk("sb_bin", 32'(bin_sw), 32'(e.b));
                chk("sb_red", 32'(bin_red_sw), 32'(e.r));
            end
        end
    endtask

    task automatic send(input logic [9:0] c, input logic [16:0] th,
                        input logic [5:0] b, input logic r);
        exp_t e;
        code       = c;
        code_valid = 1'b1;
        e.due = cyc + 2;
        e.th  = th;
        e.b   = b;
        e.r   = r;
        sb.push_back(e);
        step();
        code_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pdb"}, 32'(pdb), 32'd0);
        chk({tag, "_ready"}, 32'(code_ready), 32'd0);
        chk({tag, "_therm"}, 32'(therm_sw), 32'd0);
        chk({tag, "_bin"}, 32'(bin_sw), 32'd0);
        chk({tag, "_red"}, 32'(bin_red_sw), 32'd0);
        chk({tag, "_atb"}, 32'(atb_ena), 32'd0);
        chk({tag, "_state"}, 32'(pwr_state), 32'd0);
    endtask

    task automatic powerup();
        en = 1'b1;
        step();
        chk("pu_pdb", 32'(pdb), 32'd1);
        chk("pu_state_settle", 32'(pwr_state), 32'd1);
        chk("pu_ready_low", 32'(code_ready), 32'd0);
        chk("pu_atb_settle", 32'(atb_ena), 32'd0);
        repeat (63) step();
        chk("pu_ready_still_low", 32'(code_ready), 32'd0);
        step();
        chk("pu_ready_high", 32'(code_ready), 32'd1);
        chk("pu_state_active", 32'(pwr_state), 32'd2);
        chk("pu_atb_active", 32'(atb_ena), 32'(atb_sel));
    endtask

    task automatic powerdown();
        en = 1'b0;
        step();
        chk("pd_state_rampdn", 32'(pwr_state), 32'd3);
        chk("pd_pdb_high", 32'(pdb), 32'd1);
        chk("pd_therm_open", 32'(therm_sw), 32'd0);
        chk("pd_bin_open", 32'(bin_sw), 32'd0);
        step();
        check_all_zero("pd_off");
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dem_en = 1'b0; spare_sel = 5'd31;
        lsb_red_en = 1'b0; atb_sel = 2'b10; code = '0; code_valid = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check_all_zero("idle_off");

        // DEM off, no spare, plain decode
        powerup();
        send(10'h2C5, 17'h007FF, 6'h05, 1'b0);
        step();
        step();
        chk("hold_therm", 32'(therm_sw), 32'h007FF);

        // Power down with a code in flight: it must never reach the switches
        code = 10'h3FF; code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        powerdown();
        step();
        chk("flushed_therm", 32'(therm_sw), 32'd0);

        // Rotational DEM with wrap
        dem_en = 1'b1;
        powerup();
        dem_en = 1'b0;
        send(10'h16A, 17'h0001F, 6'h2A, 1'b0);
        send(10'h1C0, 17'h00FE0, 6'h00, 1'b0);
        send(10'h1BF, 17'h0F003, 6'h3F, 1'b0);
        send(10'h040, 17'h00004, 6'h00, 1'b0);
        step();
        step();
        powerdown();

        // Spare unit and redundant LSB
        spare_sel = 5'd3; lsb_red_en = 1'b1;
        powerup();
        send(10'h101, 17'h10007, 6'h00, 1'b1);
        send(10'h3FF, 17'h17FF7, 6'h3E, 1'b1);
        send(10'h000, 17'h00000, 6'h00, 1'b0);
        spare_sel = 5'd5; lsb_red_en = 1'b0;
        send(10'h101, 17'h10007, 6'h00, 1'b1);
        step();
        step();
        chk("spare_frozen", 32'(therm_sw), 32'h10007);

        // Reset in ACTIVE with switches closed
        rst = 1'b1;
        step();
        check_all_zero("mid_rst");
        rst = 1'b0; en = 1'b0;
        step();

        // Abort from SETTLE returns to OFF next cycle
        en = 1'b1;
        step();
        chk("abort_settle", 32'(pwr_state), 32'd1);
        step();
        en = 1'b0;
        step();
        check_all_zero("abort_off");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
